// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: register ids and hazard sources in,
// stall/flush/forward controls and status out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E;
  logic [4:0]       RdE, RdM, RdW;
  logic             ResultSrcE0;
  logic             RegWriteM, RegWriteW;
  logic             PCSrcE;
  logic             MemReqM, MemReadyM;

  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MemBusy, MemErr;
  logic [CNT_W-1:0] StallCount, FlushCount;

  // Pipeline datapath side.
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE0,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemBusy, MemErr, StallCount, FlushCount
  );

  // Hazard controller side.
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE0,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemBusy, MemErr, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage RISC-V pipeline: operand forwarding,
// load-use / branch / memory-wait sequencing, wait-timeout flag, event counters.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t             state, state_n;
  logic [TMO_W-1:0]   wait_cnt, wait_cnt_n;
  logic               mem_err, mem_err_n;
  logic [CNT_W-1:0]   stall_count, flush_count;

  logic               mem_wait, lw_stall;
  logic               stall_f, stall_d, stall_e, stall_m;
  logic               flush_d, flush_e, flush_w;

  // M stage result is newer than W, so it wins when both match.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs, input logic [4:0] rd_m, input logic wr_m,
    input logic [4:0] rd_w, input logic wr_w
  );
    if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  assign bus.ForwardAE = fwd_sel(bus.Rs1E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);
  assign bus.ForwardBE = fwd_sel(bus.Rs2E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);

  assign mem_wait = bus.MemReqM && !bus.MemReadyM;
  assign lw_stall = bus.ResultSrcE0 && bus.RdE != 5'd0 &&
                    (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (reset) begin
      if (mem_wait) begin
        // Freeze everything up to M; W gets a bubble while M is stuck.
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (bus.PCSrcE) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign bus.StallF = stall_f;
  assign bus.StallD = stall_d;
  assign bus.StallE = stall_e;
  assign bus.StallM = stall_m;
  assign bus.FlushD = flush_d;
  assign bus.FlushE = flush_e;
  assign bus.FlushW = flush_w;

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    mem_err_n  = mem_err;
    unique case (state)
      RUN: begin
        if (mem_wait) begin
          state_n    = MEM_WAIT;
          wait_cnt_n = TMO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (wait_cnt == TMO_W'(MEM_TIMEOUT)) mem_err_n = 1'b1;
        // Completion or a withdrawn request both end the wait.
        if (bus.MemReadyM || !bus.MemReqM) begin
          state_n    = RUN;
          wait_cnt_n = '0;
        end else if (wait_cnt != '1) begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_err     <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      // NOTE: non-blocking so all state updates see pre-edge values.
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      mem_err  <= mem_err_n;
      if (stall_f && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (flush_d && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end

  assign bus.MemBusy    = (state == MEM_WAIT);
  assign bus.MemErr     = mem_err;
  assign bus.StallCount = stall_count;
  assign bus.FlushCount = flush_count;

endmodule
